alu_share_arbiter: RTL
======================

// Module: alu_share_arbiter
// PURPOSE
//  Shares one combinational ALU between two requesters (req0 = execute stage, req1 = branch/address unit).
//  Round-robin grant, registered operand stage and valid/ready response channel tagged with requester id.
//  Sits between the issue logic and the ALU instance; the ALU itself is external, wired to alu_* ports.
// PARAMETERS
//  WIDTH   32  operand/result width; must match ALU width parameter
// PORTS
//  clk           in   1      clock, all state on rising edge
//  rst_n         in   1      asynchronous active-low reset
//  req0_valid    in   1      requester 0 has an operation
//  req0_ready    out  1      requester 0 operation accepted this cycle
//  req0_a/req0_b in   WIDTH  operands A/B
//  req0_func     in   4      {func7 bit, func3}
//  req0_aluop    in   3      ALU operation class
//  req1_*        -    -      identical set for requester 1
//  alu_dataA     out  WIDTH  to ALU dataA
//  alu_dataB     out  WIDTH  to ALU dataB
//  alu_func      out  4      to ALU func
//  alu_aluop     out  3      to ALU aluOp
//  alu_result    in   WIDTH  from ALU aluResult
//  alu_branch    in   1      from ALU branchFromAlu
//  rsp_valid     out  1      response available
//  rsp_ready     in   1      consumer takes response
//  rsp_id        out  1      requester that issued this response
//  rsp_result    out  WIDTH  ALU result
//  rsp_branch    out  1      ALU branch flag
// BEHAVIOUR
//  - Reset: rsp_valid=0, rsp_id=0, operand regs (alu_dataA/B, alu_func, alu_aluop)=0, rsp_result=0, rsp_branch=0,
//    last_grant=1 (req0 wins first contest). Reset mid-operation drops any pending response; no replay.
//  - slot_free = !rsp_valid | rsp_ready. Grant only when slot_free; at most one grant per cycle.
//  - Arbitration: only one valid -> grant it; both valid -> grant requester != last_grant; last_grant updates on grant.
//  - reqN_ready is combinational = slot_free & granted N; handshake completes when reqN_valid & reqN_ready.
//    Requester must hold its fields stable while valid and not ready.
//  - On accept: operands/func/aluop/id registered into the operand stage, which drives alu_* directly.
//  - alu_* hold their last values when nothing is accepted (no toggling while idle).
//  - Without ALU_RESULT_REG_EN: states IDLE/HOLD. Accept -> HOLD, rsp_valid=1 on next cycle (latency 1);
//    rsp_result/rsp_branch = alu_result/alu_branch passed through combinationally, stable because operands held.
//    HOLD & rsp_ready & new grant -> stay HOLD (throughput 1 op/cycle); HOLD & rsp_ready & no grant -> IDLE.
//  - HOLD & !rsp_ready: rsp_* stable, both reqN_ready=0.
//  - Simultaneous rsp_ready and new accept: old response retires and new operands load on the same edge.
// CONFIGURATION
//  ALU_RESULT_REG_EN defined: extra result register; states IDLE/EXEC/HOLD. Accept -> EXEC; EXEC captures
//    alu_result/alu_branch/id into rsp regs -> HOLD with rsp_valid=1 (latency 2). slot_free also requires state!=EXEC,
//    so throughput is 1 op per 2 cycles; rsp_* come only from registers.
//  Not defined: pass-through as above, latency 1, 1 op/cycle.
// TESTING
//  - req0 a=5 b=3 aluop=000 func=0, rsp_ready=1 -> cycle+1: rsp_valid=1 rsp_id=0 rsp_result=8 (+1 cycle with _EN).
//  - After reset req0 and req1 both valid continuously -> grants alternate 0,1,0,1; rsp_id follows same order.
//  - rsp_ready=0 for 3 cycles with both valid -> rsp_* unchanged, req0_ready=req1_ready=0; resume on rsp_ready=1.
//  - req1 aluop=010 func=0000 a=b=7 -> rsp_result=14, rsp_branch=1; func=1000 a=9 b=4 -> rsp_result=5.
//  - Assert rst_n low while rsp_valid=1 -> rsp_valid=0 immediately (async); first grant after release goes to req0.
//  - Back-to-back req0 stream, rsp_ready=1 -> one response/cycle (one per 2 cycles with ALU_RESULT_REG_EN).

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one external ALU between two requesters, with a registered operand stage.
// Optional ALU_RESULT_REG_EN adds a result register (latency 2, one op per 2 cycles); default is pass-through.
module alu_share_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [3:0]       req0_func,
    input  logic [2:0]       req0_aluop,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [3:0]       req1_func,
    input  logic [2:0]       req1_aluop,
    output logic [WIDTH-1:0] alu_dataA,
    output logic [WIDTH-1:0] alu_dataB,
    output logic [3:0]       alu_func,
    output logic [2:0]       alu_aluop,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_branch,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_branch
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd2;
`ifdef ALU_RESULT_REG_EN
    localparam logic [1:0] ST_EXEC = 2'd1;
`endif

    logic [1:0]       state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic [3:0]       func_q;
    logic [2:0]       aluop_q;
    logic             id_q;

    logic slot_free, sel0, sel1, accept;

    always_comb begin
`ifdef ALU_RESULT_REG_EN
        slot_free = (state_q != ST_EXEC) && ((state_q != ST_HOLD) || rsp_ready);
`else
        slot_free = (state_q != ST_HOLD) || rsp_ready;
`endif
        // Requester 1 wins when alone, or in a contest when requester 0 was granted last.
        sel1   = req1_valid && (!req0_valid || !last_grant_q);
        sel0   = req0_valid && !sel1;
        accept = slot_free && (req0_valid || req1_valid);
    end

    assign req0_ready = slot_free && sel0;
    assign req1_ready = slot_free && sel1;

    always_comb begin
        state_d      = state_q;
        last_grant_d = accept ? sel1 : last_grant_q;
`ifdef ALU_RESULT_REG_EN
        if (state_q == ST_EXEC) begin
            state_d = ST_HOLD;
        end else if (slot_free) begin
            state_d = accept ? ST_EXEC : ST_IDLE;
        end
`else
        if (slot_free) begin
            state_d = accept ? ST_HOLD : ST_IDLE;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            a_q          <= '0;
            b_q          <= '0;
            func_q       <= '0;
            aluop_q      <= '0;
            id_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            if (accept) begin
                a_q     <= sel1 ? req1_a     : req0_a;
                b_q     <= sel1 ? req1_b     : req0_b;
                func_q  <= sel1 ? req1_func  : req0_func;
                aluop_q <= sel1 ? req1_aluop : req0_aluop;
                id_q    <= sel1;
            end
        end
    end

    assign alu_dataA = a_q;
    assign alu_dataB = b_q;
    assign alu_func  = func_q;
    assign alu_aluop = aluop_q;
    assign rsp_valid = (state_q == ST_HOLD);

`ifdef ALU_RESULT_REG_EN
    logic [WIDTH-1:0] rsp_result_q;
    logic             rsp_branch_q, rsp_id_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_result_q <= '0;
            rsp_branch_q <= 1'b0;
            rsp_id_q     <= 1'b0;
        end else if (state_q == ST_EXEC) begin
            rsp_result_q <= alu_result;
            rsp_branch_q <= alu_branch;
            rsp_id_q     <= id_q;
        end
    end

    assign rsp_result = rsp_result_q;
    assign rsp_branch = rsp_branch_q;
    assign rsp_id     = rsp_id_q;
`else
    // Operands stay registered while HOLD, so the ALU output is stable enough to pass straight through.
    assign rsp_result = alu_result;
    assign rsp_branch = alu_branch;
    assign rsp_id     = id_q;
`endif

endmodule
